// File: rtl/host_loader_pkg.sv
// Shared definitions for the host loader: session state encoding and memory strides.
// Instruction memory is addressed in 32-bit words, data memory in 64-bit words.
package host_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
        ST_DUMP_OUT,
        ST_FINISH
    } state_e;

    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;

    // Where a session goes once the run phase is over (or skipped).
    function automatic state_e phase_after_run(input logic dump_empty);
        return dump_empty ? ST_FINISH : ST_DUMP_RD;
    endfunction

endpackage

// File: rtl/dump_skid.sv
// One-entry valid/ready output register holding the word being dumped to the host.
// The entry is loaded from the data-memory read port and released on a handshake.
module dump_skid #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         fire_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign fire_o  = valid_q & ready_i;

endmodule

// File: rtl/host_loader.sv
// Host-side session controller: streams a program into instruction memory, runs the CPU
// for a fixed cycle count, then reads a window of data memory back out to the host.
module host_loader
    import host_loader_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RUN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_instr,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [63:0]      dump_base,
    input  logic [CNT_W-1:0] dump_len,
    input  logic             word_valid,
    input  logic [31:0]      word_data,
    output logic             word_ready,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             cpu_enable,
    output logic             dump_valid,
    output logic [63:0]      dump_data,
    input  logic             dump_ready,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [CNT_W-1:0] num_instr_q;
    logic [CNT_W-1:0] dump_len_q;
    logic [CNT_W-1:0] load_idx_q;
    logic [CNT_W-1:0] dump_idx_q;
    logic [RUN_W-1:0] run_cnt_q;
    logic [63:0]      dump_base_q;

    state_e after_run_d;
    state_e after_load_d;
    logic   word_fire;
    logic   last_word;
    logic   last_dump;
    logic   skid_load;
    logic   skid_fire;

    // Skip targets are resolved combinationally so empty phases chain within one edge.
    always_comb begin
        after_run_d  = phase_after_run(dump_len_q == '0);
        after_load_d = (run_cnt_q == '0) ? after_run_d : ST_RUN;
    end

    assign word_ready = (state_q == ST_LOAD) && (num_instr_q != '0);
    assign word_fire  = word_ready && word_valid;
    assign last_word  = (load_idx_q == num_instr_q - CNT_W'(1));
    assign last_dump  = (dump_idx_q == dump_len_q - CNT_W'(1));
    assign skid_load  = (state_q == ST_DUMP_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_instr_q <= '0;
            dump_len_q  <= '0;
            load_idx_q  <= '0;
            dump_idx_q  <= '0;
            run_cnt_q   <= '0;
            dump_base_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_instr_q <= num_instr;
                        run_cnt_q   <= run_cycles;
                        dump_base_q <= dump_base;
                        dump_len_q  <= dump_len;
                        load_idx_q  <= '0;
                        dump_idx_q  <= '0;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (num_instr_q == '0) begin
                        state_q <= after_load_d;
                    end else if (word_fire) begin
                        if (last_word) begin
                            state_q <= after_load_d;
                        end else begin
                            load_idx_q <= load_idx_q + CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    run_cnt_q <= run_cnt_q - RUN_W'(1);
                    if (run_cnt_q == RUN_W'(1)) begin
                        state_q <= after_run_d;
                    end
                end
                ST_DUMP_RD: begin
                    state_q <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    state_q <= ST_DUMP_OUT;
                end
                ST_DUMP_OUT: begin
                    if (skid_fire) begin
                        if (last_dump) begin
                            state_q <= ST_FINISH;
                        end else begin
                            dump_idx_q <= dump_idx_q + CNT_W'(1);
                            state_q    <= ST_DUMP_RD;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory strobes and addresses are zero whenever the port is not being used.
    always_comb begin
        wen_ext    = word_fire;
        addr_ext   = word_fire ? (64'(load_idx_q) * 64'(IMEM_STRIDE)) : 64'd0;
        wdata_ext  = word_fire ? word_data : 32'd0;
        ren_ext    = 1'b0;
        ren_ext_2  = (state_q == ST_DUMP_RD);
        addr_ext_2 = ren_ext_2 ? (dump_base_q + 64'(dump_idx_q) * 64'(DMEM_STRIDE)) : 64'd0;
        wen_ext_2  = 1'b0;
        wdata_ext_2 = 64'd0;
        cpu_enable = (state_q == ST_RUN);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_FINISH);
    end

    dump_skid #(
        .W (64)
    ) u_dump_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .data_i  (rdata_ext_2),
        .ready_i (dump_ready),
        .valid_o (dump_valid),
        .data_o  (dump_data),
        .fire_o  (skid_fire)
    );

endmodule

// File: tb/tb_host_loader.sv
// Randomized self-checking bench for host_loader: a sync-read data memory model plus
// monitors logging every strobe, compared against what each session should produce.
module tb_host_loader;

    localparam int CNT_W = 16;
    localparam int RUN_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_instr = '0;
    logic [RUN_W-1:0] run_cycles = '0;
    logic [63:0]      dump_base = '0;
    logic [CNT_W-1:0] dump_len = '0;
    logic             word_valid = 1'b0;
    logic [31:0]      word_data = '0;
    logic             word_ready;
    logic [63:0]      addr_ext;
    logic             wen_ext;
    logic             ren_ext;
    logic [31:0]      wdata_ext;
    logic [63:0]      addr_ext_2;
    logic             wen_ext_2;
    logic             ren_ext_2;
    logic [63:0]      wdata_ext_2;
    logic [63:0]      rdata_ext_2 = '0;
    logic             cpu_enable;
    logic             dump_valid;
    logic [63:0]      dump_data;
    logic             dump_ready = 1'b0;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    host_loader #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_instr(num_instr), .run_cycles(run_cycles),
        .dump_base(dump_base), .dump_len(dump_len), .word_valid(word_valid),
        .word_data(word_data), .word_ready(word_ready), .addr_ext(addr_ext),
        .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .cpu_enable(cpu_enable),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [63:0] rq[$];
    logic [63:0] dq[$];
    logic [31:0] fixed_words[$];
    logic [63:0] dmem[logic [63:0]];
    int          en_cycles, en_bursts, done_cycles, static_viol, stab_viol;
    logic        prev_en = 1'b0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_data = '0;
    int          vectors = 0;
    int          miscompares = 0;

    // Data memory: one-cycle synchronous read; unloaded addresses return a poison word.
    always @(posedge clk) begin
        if (ren_ext_2) begin
            if (dmem.exists(addr_ext_2)) rdata_ext_2 <= dmem[addr_ext_2];
            else rdata_ext_2 <= 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    always @(negedge clk) begin
        if (wen_ext === 1'b1) wq.push_back({addr_ext, wdata_ext});
        if (ren_ext_2 === 1'b1) rq.push_back(addr_ext_2);
        if (dump_valid === 1'b1 && dump_ready) dq.push_back(dump_data);
        if (cpu_enable === 1'b1) en_cycles++;
        if (cpu_enable === 1'b1 && !prev_en) en_bursts++;
        prev_en = (cpu_enable === 1'b1);
        if (done === 1'b1) done_cycles++;
        if (ren_ext !== 1'b0 || wen_ext_2 !== 1'b0 || wdata_ext_2 !== 64'd0) static_viol++;
        if (wen_ext === 1'b0 && addr_ext !== 64'd0) static_viol++;
        if (ren_ext_2 === 1'b0 && addr_ext_2 !== 64'd0) static_viol++;
        if (wen_ext === 1'b1 && !(word_valid && word_ready)) static_viol++;
        if (prev_hold && (dump_valid !== 1'b1 || dump_data !== prev_data)) stab_viol++;
        prev_hold = (dump_valid === 1'b1) && !dump_ready;
        prev_data = dump_data;
    end

    task automatic clear_logs();
        wq.delete();
        rq.delete();
        dq.delete();
        en_cycles = 0;
        en_bursts = 0;
        done_cycles = 0;
        static_viol = 0;
        stab_viol = 0;
    endtask

    task automatic recover();
        rst = 1'b1;
        start = 1'b0;
        word_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One complete session: program load, run, dump. Expectations come from the arguments.
    task automatic do_session(input string tag, input int num, input int run,
                              input logic [63:0] base, input int len, input int gap_pct,
                              input int stall_at, input int rdy_mode,
                              input int expect_cycles, input int poke_start);
        logic [31:0] words[$];
        int idx, guard, stall, lowcnt, done_at;
        bit seen;
        words.delete();
        for (int i = 0; i < num; i++)
            words.push_back(fixed_words.size() > i ? fixed_words[i] : $urandom);
        dmem.delete();
        for (int j = 0; j < len; j++) dmem[base + 64'(8 * j)] = {$urandom, $urandom};
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; num_instr = CNT_W'(num); run_cycles = RUN_W'(run);
        dump_base = base; dump_len = CNT_W'(len);
        @(posedge clk); #1;
        start = 1'b0; num_instr = CNT_W'($urandom); run_cycles = $urandom;
        dump_base = {$urandom, $urandom}; dump_len = CNT_W'($urandom);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
        idx = 0; guard = 0; stall = 0;
        while (idx < num && guard < 5000) begin
            if (idx == stall_at && stall < 5) begin
                word_valid = 1'b0;
                stall++;
            end else begin
                word_valid = ($urandom_range(99) >= 32'(gap_pct));
            end
            word_data = word_valid ? words[idx] : $urandom;
            @(negedge clk);
            if (idx == stall_at && !word_valid && stall <= 5) begin
                vectors++;
                if (wen_ext !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s stall_no_wen: got %b want 0", tag, wen_ext);
                end
            end
            if (word_valid && word_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        word_valid = 1'b0;
        if (idx < num) begin
            miscompares++;
            $display("FAIL %s load_timeout: accepted %0d want %0d", tag, idx, num);
        end
        if (num > 0) begin
            vectors++;
            if (cpu_enable !== (run > 0)) begin
                miscompares++;
                $display("FAIL %s run_after_load: got %b want %b", tag, cpu_enable, run > 0);
            end
        end
        guard = 0; seen = 0; lowcnt = 0; done_at = -1;
        while (!seen && guard < 3000) begin
            if (rdy_mode == 1 && lowcnt < 7) begin
                dump_ready = 1'b0;
                if (dump_valid) lowcnt++;
            end else if (rdy_mode == 2) begin
                dump_ready = 1'b1;
            end else begin
                dump_ready = 1'($urandom_range(1));
            end
            if (poke_start != 0) begin
                start = ($urandom_range(3) == 0);
                num_instr = CNT_W'($urandom);
                dump_len = CNT_W'($urandom);
            end
            @(negedge clk);
            if (done) begin
                seen = 1;
                done_at = guard;
            end
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        dump_ready = 1'b0;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, guard);
            recover();
            return;
        end
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s back_to_idle: done=%b busy=%b want 0 0", tag, done, busy);
        end
        vectors++;
        if (wq.size() != num) begin
            miscompares++;
            $display("FAIL %s imem_writes: got %0d want %0d", tag, wq.size(), num);
        end
        for (int i = 0; i < num && i < wq.size(); i++) begin
            vectors++;
            if (wq[i].addr !== 64'(4 * i) || wq[i].data !== words[i]) begin
                miscompares++;
                $display("FAIL %s imem_write[%0d]: got %h/%h want %h/%h", tag, i,
                         wq[i].addr, wq[i].data, 64'(4 * i), words[i]);
            end
        end
        vectors++;
        if (en_cycles != run || en_bursts != (run > 0 ? 1 : 0)) begin
            miscompares++;
            $display("FAIL %s cpu_enable: got %0d cycles in %0d bursts want %0d", tag,
                     en_cycles, en_bursts, run);
        end
        vectors++;
        if (rq.size() != len) begin
            miscompares++;
            $display("FAIL %s dmem_reads: got %0d want %0d", tag, rq.size(), len);
        end
        for (int j = 0; j < len && j < rq.size(); j++) begin
            vectors++;
            if (rq[j] !== base + 64'(8 * j)) begin
                miscompares++;
                $display("FAIL %s read_addr[%0d]: got %h want %h", tag, j, rq[j],
                         base + 64'(8 * j));
            end
        end
        vectors++;
        if (dq.size() != len) begin
            miscompares++;
            $display("FAIL %s dump_words: got %0d want %0d", tag, dq.size(), len);
        end
        for (int j = 0; j < len && j < dq.size(); j++) begin
            vectors++;
            if (dq[j] !== dmem[base + 64'(8 * j)]) begin
                miscompares++;
                $display("FAIL %s dump_data[%0d]: got %h want %h", tag, j, dq[j],
                         dmem[base + 64'(8 * j)]);
            end
        end
        vectors++;
        if (done_cycles != 1 || static_viol != 0 || stab_viol != 0) begin
            miscompares++;
            $display("FAIL %s protocol: done_cycles=%0d static=%0d unstable=%0d want 1 0 0",
                     tag, done_cycles, static_viol, stab_viol);
        end
        if (rdy_mode == 1) begin
            vectors++;
            if (lowcnt != 7) begin
                miscompares++;
                $display("FAIL %s backpressure_hold: got %0d want 7", tag, lowcnt);
            end
        end
        if (expect_cycles >= 0) begin
            vectors++;
            if (done_at != expect_cycles) begin
                miscompares++;
                $display("FAIL %s session_latency: got %0d want %0d", tag, done_at,
                         expect_cycles);
            end
        end
        $display("session %s: num=%0d run=%0d base=%h len=%0d", tag, num, run, base, len);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        word_valid = 1'b1;
        dump_ready = 1'b1;
        num_instr = 5; run_cycles = 5; dump_len = 5;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({word_ready, wen_ext, ren_ext, ren_ext_2, wen_ext_2, cpu_enable, dump_valid,
             busy, done} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 0", {word_ready, wen_ext, ren_ext,
                     ren_ext_2, wen_ext_2, cpu_enable, dump_valid, busy, done});
        end
        vectors++;
        if ({addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, dump_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_buses: got nonzero addr/data want 0");
        end
        rst = 1'b0;
        start = 1'b0;
        word_valid = 1'b0;
        dump_ready = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        $display("reset applied");
    endtask

    task automatic test_skips();
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; num_instr = 0; run_cycles = 0; dump_len = 0; dump_base = {$urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL skip_load_cycle: busy=%b done=%b want 1 0", busy, done);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL skip_done: got %b want 1", done);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL skip_idle: done=%b busy=%b want 0 0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wq.size() != 0 || rq.size() != 0 || en_cycles != 0 || done_cycles != 1) begin
            miscompares++;
            $display("FAIL skip_strobes: wen=%0d ren=%0d en=%0d done=%0d want 0 0 0 1",
                     wq.size(), rq.size(), en_cycles, done_cycles);
        end
        $display("session skips: all phases empty");
    endtask

    task automatic test_reset_in_run();
        int cnt, guard;
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; num_instr = 0; run_cycles = 10; dump_len = 1; dump_base = 64'h40;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0; guard = 0;
        while (cnt < 4 && guard < 50) begin
            @(posedge clk); #1;
            if (cpu_enable) cnt++;
            guard++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (cpu_enable !== 1'b0 || busy !== 1'b0 || ren_ext_2 !== 1'b0 || wen_ext !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_run: en=%b busy=%b ren2=%b wen=%b want 0", cpu_enable,
                     busy, ren_ext_2, wen_ext);
        end
        vectors++;
        if (dump_data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_hold_clear: got %h want 0", dump_data);
        end
        repeat (12) @(posedge clk);
        #1;
        vectors++;
        if (en_cycles != 4 || rq.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_run_after: en=%0d reads=%0d busy=%b want 4 0 0",
                     en_cycles, rq.size(), busy);
        end
        $display("session reset_in_run: reset after %0d run cycles", cnt);
    endtask

    initial begin
        test_reset();
        fixed_words = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        do_session("load_run_dump", 3, 10, 64'h10, 2, 0, -1, 2, -1, 0);
        fixed_words.delete();
        do_session("stall", 4, 3, 64'h100, 1, 0, 1, 2, -1, 0);
        do_session("backpressure", 2, 2, 64'h200, 2, 0, -1, 1, -1, 0);
        test_skips();
        do_session("back_to_back", 0, 0, 64'h800, 4, 0, -1, 2, 13, 0);
        do_session("wrap", 1, 1, 64'hFFFF_FFFF_FFFF_FFF0, 4, 20, -1, 0, -1, 1);
        test_reset_in_run();
        for (int s = 0; s < 12; s++) begin
            do_session($sformatf("random%0d", s), $urandom_range(6), $urandom_range(12),
                       {$urandom, $urandom}, $urandom_range(4), 30, -1, 0, -1, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/host_loader.md
HOST_LOADER -- requirements
Module: host_loader

Interface
REQ-001 SHALL have parameter CNT_W, 16, width of the instruction-count and dump-length fields.
REQ-002 SHALL have parameter RUN_W, 32, width of the run-cycle count.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports start in 1 (session request pulse), num_instr in CNT_W, run_cycles in RUN_W, dump_base in 64 (byte address), dump_len in CNT_W (64-bit words).
REQ-006 SHALL have ports word_valid in 1, word_data in 32, word_ready out 1, forming the host instruction stream.
REQ-007 SHALL have ports addr_ext out 64, wen_ext out 1, ren_ext out 1, wdata_ext out 32, driving the CPU instruction-memory external port.
REQ-008 SHALL have ports addr_ext_2 out 64, wen_ext_2 out 1, ren_ext_2 out 1, wdata_ext_2 out 64, rdata_ext_2 in 64, driving the CPU data-memory external port.
REQ-009 SHALL have ports cpu_enable out 1, dump_valid out 1, dump_data out 64, dump_ready in 1, busy out 1, done out 1.

Function
REQ-010 SHALL implement the states IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT and FINISH.
REQ-011 In IDLE, start=1 SHALL latch all session inputs and enter LOAD; start SHALL be ignored in every other state.
REQ-012 Zero-length phases SHALL be skipped: num_instr=0 → RUN, run_cycles=0 → DUMP_RD, dump_len=0 → FINISH, with chained skips taken in the same cycle.
REQ-013 In LOAD, word_ready SHALL be 1, and each cycle with word_valid&word_ready SHALL assert wen_ext=1 with addr_ext=4*i and wdata_ext=word_data for word index i (0..num_instr-1), all combinationally in that cycle.
REQ-014 LOAD SHALL exit to RUN in the cycle after word num_instr-1 is accepted; wen_ext SHALL be 0 whenever no word is accepted.
REQ-015 In RUN, cpu_enable SHALL be 1 for exactly run_cycles consecutive cycles, counted by a RUN_W down-counter, then the block SHALL enter DUMP_RD; cpu_enable SHALL be 0 in every other state.
REQ-016 In DUMP_RD, the block SHALL assert ren_ext_2=1 for one cycle with addr_ext_2=dump_base+8*j, where j is the word index, using 64-bit wrap-around addition.
REQ-017 In DUMP_WAIT, the block SHALL capture rdata_ext_2, given one-cycle synchronous SRAM read latency, into a 64-bit hold register.
REQ-018 In DUMP_OUT, dump_valid SHALL be 1 and dump_data SHALL equal the hold register, stable until dump_ready=1.
REQ-019 On dump_valid&dump_ready the block SHALL go to DUMP_RD for j+1, or to FINISH after word dump_len-1; the best case is 3 cycles per dumped word.
REQ-020 FINISH SHALL pulse done=1 for exactly one cycle, then return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 wen_ext_2 SHALL be 0 and wdata_ext_2 SHALL be 0 at all times.
REQ-023 ren_ext SHALL be 0 at all times.
REQ-024 addr_ext and addr_ext_2 SHALL be 0 when not in use.
REQ-025 wen_ext and ren_ext_2 SHALL never be 1 outside LOAD and DUMP_RD respectively.

Reset
REQ-026 rst=1 SHALL force IDLE, clear all counters and the hold register, and drive every output to 0, taking effect at the next clock edge.
REQ-027 rst asserted mid-session, including during RUN, SHALL drop cpu_enable, wen_ext and ren_ext_2 at that edge with no further memory access; the partially loaded memory contents are not restored.

Structure
REQ-028 A shared package SHALL hold the state enumeration and the constants IMEM_STRIDE=4 and DMEM_STRIDE=8.
REQ-029 The FSM, counters and address generation SHALL form one module.
REQ-030 A sub-module dump_skid, a one-entry valid/ready output register, is natural and SHALL own dump_valid and dump_data.

Verification
REQ-031 Load: num_instr=3, words 0x00500093, 0x00A00113, 0x002081B3 presented back-to-back → wen_ext pulses at addr_ext 0, 4, 8 with matching wdata_ext, then RUN.
REQ-032 Stall: word_valid low for 5 cycles between words 1 and 2 → no wen_ext in the gap, and the address resumes at 4.
REQ-033 Run/dump: run_cycles=10 → cpu_enable high exactly 10 cycles; then dump_base=0x10, dump_len=2 → ren_ext_2 at 0x10 and 0x18, and dump_data equals the preloaded words, in order.
REQ-034 Backpressure: dump_ready held low for 7 cycles → dump_valid and dump_data stable, with no extra ren_ext_2.
REQ-035 Skips: num_instr=0, run_cycles=0, dump_len=0 → done one cycle after LOAD is entered, with no memory strobes.
REQ-036 Reset in RUN, with rst at cycle 4 of 10 → cpu_enable=0 at the next edge, then IDLE; a new start is accepted.
